// File: rtl/uart_rx.sv
// uart_rx: memory-mapped 8N1 UART receiver with a small receive FIFO and status/flag registers.
module uart_rx #(
  parameter logic [7:0] PERIOD = 8'h1A,
  parameter int         ADDR_W = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wren,
  input  logic       rden,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rxin,
  output logic       rxavail
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;
  state_t r_state, w_next;
  logic [7:0] r_pr, r_shreg;
  logic [8:0] r_tmr;
  logic [2:0] r_bitcnt;
  logic r_sync1, r_rx_s, r_ferr, r_ovr;
  logic [7:0] r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] r_waddr, r_raddr;
  logic w_empty, w_full, w_half, w_bit, w_pop, w_stat_wr;
  logic w_shift, w_push, w_ovr_set, w_ferr_set;
  logic [7:0] w_status, w_rdata;
  assign w_empty   = r_waddr == r_raddr;
  assign w_full    = (r_waddr + ADDR_W'(1)) == r_raddr;
  assign w_half    = r_tmr == {1'b0, r_pr};
  assign w_bit     = r_tmr == {r_pr, 1'b1};
  assign w_pop     = rden & (addr == 3'b010) & ~w_empty;
  assign w_stat_wr = wren & (addr == 3'b011);
  assign w_status  = {4'b0, r_ferr, r_ovr, w_full, ~w_empty};
  assign rxavail   = ~w_empty;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = r_rx_s ? S_IDLE : S_START;
      S_START: w_next = !w_half ? S_START : r_rx_s ? S_IDLE : S_DATA;
      S_DATA:  w_next = (w_bit && r_bitcnt == 3'd7) ? S_STOP : S_DATA;
      S_STOP:  w_next = !w_bit ? S_STOP : r_rx_s ? S_IDLE : S_BRK;
      S_BRK:   w_next = r_rx_s ? S_IDLE : S_BRK;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    w_shift    = (r_state == S_DATA) & w_bit;
    w_push     = (r_state == S_STOP) & w_bit & r_rx_s & ~w_full;
    w_ovr_set  = (r_state == S_STOP) & w_bit & r_rx_s & w_full;
    w_ferr_set = (r_state == S_STOP) & w_bit & ~r_rx_s;
  end
  // The timer also restarts after each data sample so every bit is timed from its own midpoint.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_sync1  <= 1'b1;
      r_rx_s   <= 1'b1;
      r_tmr    <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
    end else begin
      r_sync1  <= rxin;
      r_rx_s   <= r_sync1;
      r_tmr    <= (r_state != w_next || w_shift) ? 9'd0 : r_tmr + 9'd1;
      r_bitcnt <= (r_state == S_START) ? 3'd0 : w_shift ? r_bitcnt + 3'd1 : r_bitcnt;
      r_shreg  <= w_shift ? {r_rx_s, r_shreg[7:1]} : r_shreg;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_pr    <= PERIOD;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_waddr <= '0;
      r_raddr <= '0;
    end else begin
      r_pr    <= (wren && addr == 3'b000) ? din : r_pr;
      r_ferr  <= w_ferr_set | (r_ferr & ~(w_stat_wr & din[3]));
      r_ovr   <= w_ovr_set | (r_ovr & ~(w_stat_wr & din[2]));
      r_waddr <= w_push ? r_waddr + ADDR_W'(1) : r_waddr;
      r_raddr <= w_pop ? r_raddr + ADDR_W'(1) : r_raddr;
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_waddr] <= r_shreg;
  assign w_rdata = !rden ? 8'h00 :
                   addr == 3'b000 ? r_pr :
                   addr == 3'b010 ? (w_empty ? 8'h00 : r_mem[r_raddr]) :
                   addr == 3'b011 ? w_status : 8'h00;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) dout <= 8'h00;
    else dout <= w_rdata;
endmodule
